// File: rtl/odd_result_pipeline.sv
// Fixed-depth result pipeline from the odd pipe to register-file writeback.
// It provides per-stage forwarding taps and a youngest-match hazard query.
// Define ODD_RESULT_STATS_EN to add the saturating writeback and flush counters.
module odd_result_pipeline #(
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int LAT_W  = 4,
  parameter int UNIT_W = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_rt_value,
  input  logic [ADDR_W-1:0]        in_rt_address,
  input  logic                     in_reg_write,
  input  logic [LAT_W-1:0]         in_unit_latency,
  input  logic [UNIT_W-1:0]        in_unit_id,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        query_address,
  output logic                     query_hit,
  output logic                     query_ready,
  output logic [DATA_W-1:0]        query_value,
  output logic [DEPTH-1:0]         fwd_valid,
  output logic [DEPTH-1:0]         fwd_ready,
  output logic [DEPTH*ADDR_W-1:0]  fwd_rt_address,
  output logic [DEPTH*DATA_W-1:0]  fwd_rt_value,
  output logic                     wb_valid,
  output logic                     wb_reg_write,
  output logic [ADDR_W-1:0]        wb_rt_address,
  output logic [DATA_W-1:0]        wb_rt_value,
  output logic [UNIT_W-1:0]        wb_unit_id
`ifdef ODD_RESULT_STATS_EN
  ,
  output logic [31:0]              stat_wb_count,
  output logic [31:0]              stat_flush_count
`endif
);

  // Index k holds stage S(k+1): index 0 is the youngest entry, DEPTH-1 is the writeback stage.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rw_q;
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [LAT_W-1:0]  lat_q   [DEPTH];
  logic [UNIT_W-1:0] unit_q  [DEPTH];
  logic [LAT_W-1:0]  lat_d;

  // NOTE: every signal written in an always_comb gets a default on entry, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lat_d = in_unit_latency;
    if (in_unit_latency == '0) begin
      lat_d = LAT_W'(1);
    end else if (int'(in_unit_latency) > DEPTH) begin
      lat_d = LAT_W'(DEPTH);
    end
  end

  // A flush kills both the incoming capture and the entry leaving S1.
  always_comb begin
    valid_d    = {valid_q[DEPTH-2:0], in_valid & ~flush};
    valid_d[1] = valid_q[0] & ~flush;
  end

  // NOTE: the stage registers, data included, are cleared by reset, because reset must squash in-flight entries and hold every output at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rw_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k]  <= '0;
        value_q[k] <= '0;
        lat_q[k]   <= '0;
        unit_q[k]  <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every stage sees the previous value of its neighbour.
      valid_q   <= valid_d;
      rw_q      <= {rw_q[DEPTH-2:0], in_reg_write};
      addr_q[0]  <= in_rt_address;
      value_q[0] <= in_rt_value;
      lat_q[0]   <= lat_d;
      unit_q[0]  <= in_unit_id;
      for (int k = 1; k < DEPTH; k++) begin
        addr_q[k]  <= addr_q[k-1];
        value_q[k] <= value_q[k-1];
        lat_q[k]   <= lat_q[k-1];
        unit_q[k]  <= unit_q[k-1];
      end
    end
  end

  // Forwarding taps: an entry becomes ready once its age reaches its latency.
  always_comb begin
    fwd_valid      = valid_q;
    fwd_ready      = '0;
    fwd_rt_address = '0;
    fwd_rt_value   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_ready[k] = valid_q[k] & (int'(lat_q[k]) <= k + 1);
      fwd_rt_address[k*ADDR_W +: ADDR_W] = addr_q[k];
      fwd_rt_value[k*DATA_W +: DATA_W]   = value_q[k];
    end
  end

  // The scan runs from oldest to youngest, so the youngest match is the one that remains.
  always_comb begin
    query_hit   = 1'b0;
    query_ready = 1'b0;
    query_value = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && rw_q[k] && (addr_q[k] == query_address)) begin
        query_hit   = 1'b1;
        query_ready = fwd_ready[k];
        query_value = value_q[k];
      end
    end
  end

  assign wb_valid      = valid_q[DEPTH-1];
  assign wb_reg_write  = valid_q[DEPTH-1] & rw_q[DEPTH-1];
  assign wb_rt_address = addr_q[DEPTH-1];
  assign wb_rt_value   = value_q[DEPTH-1];
  assign wb_unit_id    = unit_q[DEPTH-1];

`ifdef ODD_RESULT_STATS_EN
  logic [31:0] wb_cnt_q, fl_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (wb_reg_write && (wb_cnt_q != 32'hFFFF_FFFF)) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
      if (flush && (in_valid || valid_q[0]) && (fl_cnt_q != 32'hFFFF_FFFF)) begin
        fl_cnt_q <= fl_cnt_q + 32'd1;
      end
    end
  end

  assign stat_wb_count    = wb_cnt_q;
  assign stat_flush_count = fl_cnt_q;
`endif

endmodule

// File: tb/tb_odd_result_pipeline.sv
// Self-checking bench for odd_result_pipeline: directed scenarios plus randomized traffic.
// Expected values come from a queue model of in-flight results.
module tb_odd_result_pipeline;
  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int LAT_W  = 4;
  localparam int UNIT_W = 3;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_rt_value;
  logic [ADDR_W-1:0]       in_rt_address;
  logic                    in_reg_write;
  logic [LAT_W-1:0]        in_unit_latency;
  logic [UNIT_W-1:0]       in_unit_id;
  logic                    flush;
  logic [ADDR_W-1:0]       query_address;
  logic                    query_hit, query_ready;
  logic [DATA_W-1:0]       query_value;
  logic [DEPTH-1:0]        fwd_valid, fwd_ready;
  logic [DEPTH*ADDR_W-1:0] fwd_rt_address;
  logic [DEPTH*DATA_W-1:0] fwd_rt_value;
  logic                    wb_valid, wb_reg_write;
  logic [ADDR_W-1:0]       wb_rt_address;
  logic [DATA_W-1:0]       wb_rt_value;
  logic [UNIT_W-1:0]       wb_unit_id;
`ifdef ODD_RESULT_STATS_EN
  logic [31:0]             stat_wb_count, stat_flush_count;
`endif

  odd_result_pipeline #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .UNIT_W(UNIT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_rt_value(in_rt_value), .in_rt_address(in_rt_address),
    .in_reg_write(in_reg_write), .in_unit_latency(in_unit_latency), .in_unit_id(in_unit_id),
    .flush(flush), .query_address(query_address),
    .query_hit(query_hit), .query_ready(query_ready), .query_value(query_value),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .fwd_rt_address(fwd_rt_address), .fwd_rt_value(fwd_rt_value),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rt_address(wb_rt_address),
    .wb_rt_value(wb_rt_value), .wb_unit_id(wb_unit_id)
`ifdef ODD_RESULT_STATS_EN
    , .stat_wb_count(stat_wb_count), .stat_flush_count(stat_flush_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: one queue entry per stage, index 0 = youngest; lat holds the effective latency.
  typedef struct {
    logic              v;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    int                lat;
    logic [UNIT_W-1:0] unit;
  } ent_t;

  ent_t pipe[$];
  int   m_wb, m_fl;

  function automatic int eff_lat(input logic [LAT_W-1:0] l);
    if (l == 0) return 1;
    if (int'(l) > DEPTH) return DEPTH;
    return int'(l);
  endfunction

  task automatic model_clear();
    ent_t e;
    e = '{v: 1'b0, rw: 1'b0, addr: '0, val: '0, lat: 0, unit: '0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    m_wb = 0;
    m_fl = 0;
  endtask

  task automatic model_query(input logic [ADDR_W-1:0] a, output logic h, output logic r,
                             output logic [DATA_W-1:0] d);
    h = 1'b0; r = 1'b0; d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].v && pipe[i].rw && pipe[i].addr == a) begin
        h = 1'b1;
        r = (i + 1 >= pipe[i].lat);
        d = pipe[i].val;
        return;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic rw, input logic [LAT_W-1:0] l, input logic [UNIT_W-1:0] u,
                       input logic fl);
    in_valid = v; in_rt_address = a; in_rt_value = d; in_reg_write = rw;
    in_unit_latency = l; in_unit_id = u; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Advances one clock edge and applies the same edge to the model; returns 1 time unit after the edge.
  task automatic tick();
    ent_t e;
    @(posedge clock);
    if (pipe[DEPTH-1].v && pipe[DEPTH-1].rw) m_wb++;
    if (flush && (in_valid || pipe[0].v)) m_fl++;
    if (flush) pipe[0].v = 1'b0;
    e.v = in_valid & ~flush;
    e.rw = in_reg_write;
    e.addr = in_rt_address;
    e.val = in_rt_value;
    e.lat = eff_lat(in_unit_latency);
    e.unit = in_unit_id;
    pipe.push_front(e);
    void'(pipe.pop_back());
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle();
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (fwd_valid !== '0) begin errors++; $display("FAIL reset_fwd_valid got %h exp 0", fwd_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (query_hit !== 1'b0 || query_value !== '0) begin errors++; $display("FAIL reset_query got hit=%b val=%h exp 0", query_hit, query_value); end
    checks++; if (wb_rt_value !== '0 || wb_rt_address !== '0) begin errors++; $display("FAIL reset_wb_fields got addr=%h val=%h exp 0", wb_rt_address, wb_rt_value); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_latency4();
    drain();
    drive(1'b1, 7'd5, 128'hAA, 1'b1, 4'd4, 3'd5, 1'b0);
    tick();
    idle();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      if (k <= DEPTH) begin
        checks++; if (fwd_valid[k-1] !== 1'b1) begin errors++; $display("FAIL lat4_valid_S%0d got %b exp 1", k, fwd_valid[k-1]); end
        checks++; if (fwd_ready[k-1] !== (k >= 4)) begin errors++; $display("FAIL lat4_ready_S%0d got %b exp %b", k, fwd_ready[k-1], (k >= 4)); end
      end
      checks++; if (wb_valid !== (k == DEPTH)) begin errors++; $display("FAIL lat4_wb_valid_k%0d got %b exp %b", k, wb_valid, (k == DEPTH)); end
      if (k == DEPTH) begin
        checks++;
        if (wb_rt_address !== 7'd5 || wb_rt_value !== 128'hAA || wb_reg_write !== 1'b1 || wb_unit_id !== 3'd5) begin
          errors++; $display("FAIL lat4_wb_fields got addr=%0d val=%h rw=%b unit=%0d exp 5/aa/1/5", wb_rt_address, wb_rt_value, wb_reg_write, wb_unit_id);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drain();
    for (int t = 1; t <= 14; t++) begin
      if (t <= 7) drive(1'b1, ADDR_W'(t), DATA_W'(t * 32'h1111), 1'b1, 4'd7, 3'd6, 1'b0);
      else idle();
      tick();
      checks++; if (wb_valid !== (t >= 7 && t <= 13)) begin errors++; $display("FAIL b2b_wb_valid_t%0d got %b exp %b", t, wb_valid, (t >= 7 && t <= 13)); end
      if (t >= 7 && t <= 13) begin
        checks++;
        if (wb_rt_address !== ADDR_W'(t - 6) || wb_rt_value !== DATA_W'((t - 6) * 32'h1111)) begin
          errors++; $display("FAIL b2b_wb_order_t%0d got addr=%0d val=%h exp addr=%0d", t, wb_rt_address, wb_rt_value, t - 6);
        end
      end
    end
  endtask

  task automatic test_query();
    drain();
    drive(1'b1, 7'd9, 128'h1234, 1'b1, 4'd4, 3'd5, 1'b0); tick();
    idle(); tick(); tick();
    drive(1'b1, 7'd9, 128'h5678, 1'b1, 4'd7, 3'd6, 1'b0); tick();
    idle(); tick();
    query_address = 7'd9; #1;
    checks++; if (query_hit !== 1'b1 || query_ready !== 1'b0 || query_value !== 128'h5678) begin
      errors++; $display("FAIL query_youngest got hit=%b rdy=%b val=%h exp 1/0/5678", query_hit, query_ready, query_value); end
    checks++; if (fwd_ready[4] !== 1'b1 || fwd_ready[1] !== 1'b0) begin
      errors++; $display("FAIL query_stage_ready got %b exp S5=1 S2=0", fwd_ready); end
    query_address = 7'd10; #1;
    checks++; if (query_hit !== 1'b0 || query_ready !== 1'b0 || query_value !== '0) begin
      errors++; $display("FAIL query_miss got hit=%b rdy=%b val=%h exp 0/0/0", query_hit, query_ready, query_value); end
  endtask

  task automatic test_flush();
    int wbs = 0;
`ifdef ODD_RESULT_STATS_EN
    logic [31:0] fl0;
`endif
    drain();
`ifdef ODD_RESULT_STATS_EN
    fl0 = stat_flush_count;
`endif
    drive(1'b1, 7'h11, 128'hA, 1'b1, 4'd1, 3'd7, 1'b0); tick();
    drive(1'b1, 7'h22, 128'hB, 1'b1, 4'd1, 3'd7, 1'b0); tick();
    drive(1'b1, 7'h33, 128'hC, 1'b1, 4'd1, 3'd7, 1'b1); tick();
    idle();
    checks++; if (fwd_valid[2:0] !== 3'b100) begin errors++; $display("FAIL flush_stages got %b exp 100", fwd_valid[2:0]); end
    for (int t = 0; t < 10; t++) begin
      if (wb_valid) begin
        wbs++;
        checks++; if (wb_rt_address !== 7'h11) begin errors++; $display("FAIL flush_wb_addr got %h exp 11", wb_rt_address); end
      end
      tick();
    end
    checks++; if (wbs != 1) begin errors++; $display("FAIL flush_wb_count got %0d exp 1", wbs); end
`ifdef ODD_RESULT_STATS_EN
    checks++; if (stat_flush_count - fl0 !== 32'd1) begin errors++; $display("FAIL flush_stat got %0d exp 1", stat_flush_count - fl0); end
`endif
  endtask

  task automatic test_reset_midflight();
    int wbs = 0;
    drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(20 + i), DATA_W'(i + 1), 1'b1, 4'd1, 3'd5, 1'b0);
      tick();
    end
    idle();
    query_address = 7'd21;
    #2 reset = 1'b0;
    #1;
    checks++; if (fwd_valid !== '0 || wb_valid !== 1'b0) begin errors++; $display("FAIL midreset_valids got fwd=%b wb=%b exp 0", fwd_valid, wb_valid); end
    checks++; if (query_hit !== 1'b0 || fwd_rt_value !== '0) begin errors++; $display("FAIL midreset_data got hit=%b exp hit 0 and zero values", query_hit); end
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (wb_valid) wbs++;
    end
    checks++; if (wbs != 0) begin errors++; $display("FAIL midreset_wb_after got %0d exp 0", wbs); end
  endtask

  task automatic test_latency_clamp();
    do_reset();
    drive(1'b1, 7'd3, 128'h30, 1'b1, 4'd0, 3'd7, 1'b0); tick();
    checks++; if (fwd_ready[0] !== 1'b1) begin errors++; $display("FAIL clamp_lat0_S1 got %b exp 1", fwd_ready[0]); end
    drive(1'b1, 7'd4, 128'h40, 1'b1, 4'd9, 3'd6, 1'b0); tick();
    idle();
    checks++; if (fwd_ready[1:0] !== 2'b10) begin errors++; $display("FAIL clamp_S1S2 got %b exp 10", fwd_ready[1:0]); end
    repeat (5) tick();
    checks++; if (fwd_valid[5] !== 1'b1 || fwd_ready[5] !== 1'b0) begin errors++; $display("FAIL clamp_lat9_S6 got v=%b r=%b exp 1/0", fwd_valid[5], fwd_ready[5]); end
    tick();
    checks++; if (fwd_ready[6] !== 1'b1 || wb_rt_address !== 7'd4) begin errors++; $display("FAIL clamp_lat9_S7 got r=%b addr=%0d exp 1/4", fwd_ready[6], wb_rt_address); end
    drain();
`ifdef ODD_RESULT_STATS_EN
    checks++; if (stat_wb_count !== 32'd2) begin errors++; $display("FAIL clamp_stat_wb got %0d exp 2", stat_wb_count); end
`endif
  endtask

  task automatic test_random();
    logic [DEPTH-1:0]        ev, er;
    logic [DEPTH*ADDR_W-1:0] ea;
    logic [DEPTH*DATA_W-1:0] ed;
    logic                    eh, erdy;
    logic [DATA_W-1:0]       eq;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)),
            {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom()),
            LAT_W'($urandom_range(0, 15)), UNIT_W'($urandom_range(5, 7)),
            ($urandom_range(0, 7) == 0));
      tick();
      query_address = ADDR_W'($urandom_range(0, 8));
      #1;
      for (int k = 0; k < DEPTH; k++) begin
        ev[k] = pipe[k].v;
        er[k] = pipe[k].v && (k + 1 >= pipe[k].lat);
        ea[k*ADDR_W +: ADDR_W] = pipe[k].addr;
        ed[k*DATA_W +: DATA_W] = pipe[k].val;
      end
      model_query(query_address, eh, erdy, eq);
      checks++; if (fwd_valid !== ev) begin errors++; $display("FAIL rnd_fwd_valid n=%0d got %b exp %b", n, fwd_valid, ev); end
      checks++; if (fwd_ready !== er) begin errors++; $display("FAIL rnd_fwd_ready n=%0d got %b exp %b", n, fwd_ready, er); end
      checks++; if (fwd_rt_address !== ea) begin errors++; $display("FAIL rnd_fwd_addr n=%0d got %h exp %h", n, fwd_rt_address, ea); end
      checks++; if (fwd_rt_value !== ed) begin errors++; $display("FAIL rnd_fwd_value n=%0d mismatch in stage data", n); end
      checks++;
      if (wb_valid !== pipe[DEPTH-1].v || wb_reg_write !== (pipe[DEPTH-1].v & pipe[DEPTH-1].rw) ||
          wb_rt_address !== pipe[DEPTH-1].addr || wb_rt_value !== pipe[DEPTH-1].val ||
          wb_unit_id !== pipe[DEPTH-1].unit) begin
        errors++; $display("FAIL rnd_wb n=%0d got v=%b rw=%b addr=%h exp v=%b addr=%h", n, wb_valid, wb_reg_write, wb_rt_address, pipe[DEPTH-1].v, pipe[DEPTH-1].addr);
      end
      checks++;
      if (query_hit !== eh || query_ready !== erdy || query_value !== eq) begin
        errors++; $display("FAIL rnd_query n=%0d got hit=%b rdy=%b val=%h exp hit=%b rdy=%b val=%h", n, query_hit, query_ready, query_value, eh, erdy, eq);
      end
    end
`ifdef ODD_RESULT_STATS_EN
    checks++; if (stat_wb_count !== 32'(m_wb)) begin errors++; $display("FAIL rnd_stat_wb got %0d exp %0d", stat_wb_count, m_wb); end
    checks++; if (stat_flush_count !== 32'(m_fl)) begin errors++; $display("FAIL rnd_stat_flush got %0d exp %0d", stat_flush_count, m_fl); end
`endif
  endtask

  initial begin
    idle();
    query_address = '0;
    model_clear();
    test_reset();
    test_latency4();
    test_back_to_back();
    test_query();
    test_flush();
    test_reset_midflight();
    test_latency_clamp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_result_pipeline.md
Name: odd_result_pipeline

Overview:
- Downstream of the odd pipe: captures each odd-pipe result (rt_value, rt_address, unit_latency, unit_id) and carries it through a fixed-depth result pipeline to register-file writeback.
- Exposes per-stage forwarding taps, marked ready once the producing unit's latency has elapsed.
- Provides a hazard query port for issue logic.
- Covers permute (latency 4), load/store (latency 7) and branch (latency 1) results.

Parameters:
DEPTH, 7, number of result stages; writeback taken from the last stage
DATA_W, 128, result width
ADDR_W, 7, register address width
LAT_W, 4, latency field width
UNIT_W, 3, unit id width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  odd-pipe result present this cycle
in_rt_value  input  DATA_W  result value
in_rt_address  input  ADDR_W  destination register
in_reg_write  input  1  result writes the register file (0 for stores and plain branches)
in_unit_latency  input  LAT_W  producing unit latency
in_unit_id  input  UNIT_W  producing unit (5 permute, 6 load/store, 7 branch)
flush  input  1  squash the instruction issued after a taken branch
query_address  input  ADDR_W  issue-side source register to check
query_hit  output  1  an in-flight entry with reg_write targets query_address
query_ready  output  1  hit entry's value is forwardable
query_value  output  DATA_W  hit entry's value (0 when no hit)
fwd_valid  output  DEPTH  per-stage valid; bit k-1 = stage k
fwd_ready  output  DEPTH  per-stage ready
fwd_rt_address  output  DEPTH*ADDR_W  per-stage address; stage k in slice k-1
fwd_rt_value  output  DEPTH*DATA_W  per-stage value
wb_valid  output  1  writeback entry valid
wb_reg_write  output  1  writeback writes the register file
wb_rt_address  output  ADDR_W  writeback address
wb_rt_value  output  DATA_W  writeback value
wb_unit_id  output  UNIT_W  writeback unit id

Behaviour:
- Stage registers S1..SDEPTH each hold valid, reg_write, address, value, latency and unit_id.
- Every rising edge: S1 <= input fields with valid = in_valid & ~flush; Sk+1 <= Sk. No stall; the pipeline always advances.
- Latency clamp at capture: 0 is stored as 1; values > DEPTH are stored as DEPTH.
- Ready: fwd_ready[k-1] = Sk.valid & (k >= Sk.latency). A branch link result is ready at S1; a load is ready only at S7.
- Writeback: wb_* are driven directly from SDEPTH. An entry captured at edge N appears on wb_* after edge N+DEPTH-1, for exactly one cycle.
- wb_reg_write = SDEPTH.valid & SDEPTH.reg_write. Entries with reg_write=0 still occupy stages and emit wb_valid.
- Flush squashes two things in the same edge: the incoming capture and the current S1 entry (its valid is cleared as it moves to S2). S2 and older are unaffected.
- Query:
  - Scan S1..SDEPTH for the first (youngest) stage with valid & reg_write & address == query_address.
  - hit = 1, ready/value taken from that stage.
  - No match: hit = 0, ready = 0, value = 0.
  - Purely combinational from stage registers.
- In-cycle input is not visible to the query or the forwarding taps until it is captured.
- Reset asserted (0), even mid-flight: all stage fields clear to 0 immediately. All outputs are 0 while reset is held. No squashed entry is ever written back after reset deasserts.
- Same address in multiple stages: both travel independently and both write back in order. The query reports the youngest.

Optional Feature:
ODD_RESULT_STATS_EN:
- Defined:
  - Adds outputs stat_wb_count (32) and stat_flush_count (32).
  - stat_wb_count increments on each cycle with wb_valid & wb_reg_write.
  - stat_flush_count increments on each flush cycle where the incoming capture or S1 held a valid entry.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Latency=4 entry, addr 5, value 0x00..AA, reg_write=1 -> fwd_ready is 0 at S1-S3 and 1 at S4-S7; wb_valid=1 with addr 5, value 0x00..AA, 6 edges after the capture edge, for one cycle.
- Seven back-to-back entries, addr 1..7 -> wb addrs 1..7 on consecutive cycles, no gaps, in order.
- Addr 9 at S2 (latency 7, not ready) and S5 (latency 4, ready), query_address=9 -> hit=1, ready=0, value = S2's value; query_address=10 -> hit=0, value=0.
- A at S2, B at S1, C incoming with flush=1 -> only A reaches writeback; B and C never assert wb_valid.
- Reset driven 0 with 4 entries in flight -> all fwd_valid and wb_valid drop to 0 immediately; zero writebacks after release.
- Latency 0 and latency 9 inputs -> ready at S1 and at S7 respectively. With ODD_RESULT_STATS_EN, stat_wb_count=2 after both write back.
